// File: rtl/clkdiv_multi.sv
// Multi-channel reloadable clock divider: per-channel square wave plus rising-edge tick.
// Optional macro CLKDIV_GLITCHFREE_EN defers divisor reloads to the end of a full period.
module clkdiv_multi #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int DEF_FREQ = 1,
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 26
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              div_load,
   input  logic [3:0]        div_ch,
   input  logic [CNT_W-1:0]  div_val,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   localparam logic [CNT_W-1:0] HALF_DEF = CNT_W'(CLK_FREQ / (2 * DEF_FREQ) - 1);

   logic [CNT_W-1:0]  cnt  [NUM_CH];
   logic [CNT_W-1:0]  half [NUM_CH];
   logic [NUM_CH-1:0] sel;
   logic [NUM_CH-1:0] wrap;

`ifdef CLKDIV_GLITCHFREE_EN
   logic [CNT_W-1:0]  pend_val [NUM_CH];
   logic [NUM_CH-1:0] pend_vld;
`endif

   // Out-of-range channel indices never match, so such loads drop silently.
   always_comb begin
      sel  = '0;
      wrap = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sel[i]  = div_load && (div_ch == 4'(i));
         wrap[i] = (cnt[i] == half[i]);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (!rst) begin
            cnt[i]     <= '0;
            half[i]    <= HALF_DEF;
            clk_out[i] <= 1'b0;
            tick[i]    <= 1'b0;
`ifdef CLKDIV_GLITCHFREE_EN
            pend_vld[i] <= 1'b0;
`endif
         end else if (sync) begin
            cnt[i]     <= '0;
            clk_out[i] <= 1'b0;
            tick[i]    <= 1'b0;
`ifdef CLKDIV_GLITCHFREE_EN
            if (sel[i])
               half[i] <= div_val;
            else if (pend_vld[i])
               half[i] <= pend_val[i];
            pend_vld[i] <= 1'b0;
`else
            if (sel[i])
               half[i] <= div_val;
`endif
         end
`ifndef CLKDIV_GLITCHFREE_EN
         // Immediate reload restarts the count; the current output level is kept.
         else if (sel[i]) begin
            half[i] <= div_val;
            cnt[i]  <= '0;
         end
`endif
         else begin
            if (en[i]) begin
               if (wrap[i]) begin
                  cnt[i]     <= '0;
                  clk_out[i] <= ~clk_out[i];
                  tick[i]    <= ~clk_out[i];
               end else begin
                  cnt[i]  <= cnt[i] + CNT_W'(1);
                  tick[i] <= 1'b0;
               end
            end else begin
               tick[i] <= 1'b0;
            end
`ifdef CLKDIV_GLITCHFREE_EN
            if (sel[i] && en[i]) begin
               pend_val[i] <= div_val;
               pend_vld[i] <= 1'b1;
            end else if (sel[i] || (pend_vld[i] && !en[i])) begin
               // Stopped channel takes the value now; a held count above it would never match.
               half[i]     <= sel[i] ? div_val : pend_val[i];
               pend_vld[i] <= 1'b0;
               if (cnt[i] > (sel[i] ? div_val : pend_val[i]))
                  cnt[i] <= '0;
            end else if (pend_vld[i] && wrap[i] && clk_out[i]) begin
               half[i]     <= pend_val[i];
               pend_vld[i] <= 1'b0;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi (CLK_FREQ=100, DEF_FREQ=10, NUM_CH=4: half=4, period 10).
// Reference model tracks each channel as a phase position inside its output period.
module tb_clkdiv_multi;

   localparam int CW = 8;
`ifdef CLKDIV_GLITCHFREE_EN
   localparam bit GF = 1'b1;
`else
   localparam bit GF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [3:0]    en = 4'h0;
   logic          sync = 1'b0;
   logic          div_load = 1'b0;
   logic [3:0]    div_ch = 4'h0;
   logic [CW-1:0] div_val = '0;
   logic [3:0]    clk_out;
   logic [3:0]    tick;

   int n_checks = 0;
   int n_fail   = 0;

   int m_ph [4];
   int m_half [4];
   int m_pend [4];
   bit m_pvld [4];
   bit m_tick [4];

   clkdiv_multi #(
      .CLK_FREQ(100), .DEF_FREQ(10), .NUM_CH(4), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .sync(sync), .div_load(div_load),
      .div_ch(div_ch), .div_val(div_val), .clk_out(clk_out), .tick(tick)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] m_outv();
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = (m_ph[c] >= m_half[c] + 1);
      return v;
   endfunction

   function automatic logic [3:0] m_tickv();
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = m_tick[c];
      return v;
   endfunction

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_update();
      bit ld;
      for (int c = 0; c < 4; c++) begin
         ld = div_load && (div_ch == 4'(c));
         if (!rst) begin
            m_ph[c] = 0; m_half[c] = 4; m_tick[c] = 0; m_pvld[c] = 0;
         end else if (sync) begin
            m_ph[c] = 0; m_tick[c] = 0;
            if (ld) m_half[c] = int'(div_val);
            else if (GF && m_pvld[c]) m_half[c] = m_pend[c];
            m_pvld[c] = 0;
         end else if (!GF && ld) begin
            m_ph[c] = (m_ph[c] >= m_half[c] + 1) ? int'(div_val) + 1 : 0;
            m_half[c] = int'(div_val);
         end else begin
            if (en[c]) begin
               m_ph[c]++;
               if (m_ph[c] == 2 * (m_half[c] + 1)) begin
                  m_ph[c] = 0;
                  if (m_pvld[c] && !ld) begin
                     m_half[c] = m_pend[c];
                     m_pvld[c] = 0;
                  end
               end
               m_tick[c] = (m_ph[c] == m_half[c] + 1);
            end else begin
               m_tick[c] = 0;
            end
            if (ld) begin
               m_pend[c] = int'(div_val);
               m_pvld[c] = 1;
            end
         end
      end
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 4'h0; sync = 1'b0; div_load = 1'b0;
      step(); step();
      n_checks++;
      if (clk_out !== 4'h0) begin
         n_fail++; $display("FAIL reset_clk_out: got %h expected 0", clk_out);
      end
      n_checks++;
      if (tick !== 4'h0) begin
         n_fail++; $display("FAIL reset_tick: got %h expected 0", tick);
      end
   endtask

   task automatic test_release();
      logic [3:0] eo, et;
      rst = 1'b1; en = 4'hF;
      for (int k = 1; k <= 25; k++) begin
         step();
         eo = ((k / 5) % 2 == 1) ? 4'hF : 4'h0;
         et = (k % 10 == 5) ? 4'hF : 4'h0;
         n_checks++;
         if (clk_out !== eo || tick !== et) begin
            n_fail++;
            $display("FAIL release k=%0d: got out=%h tick=%h expected out=%h tick=%h", k, clk_out, tick, eo, et);
         end
      end
   endtask

   task automatic test_div_load();
      logic prev;
      div_load = 1'b1; div_ch = 4'd1; div_val = 8'd0;
      step();
      div_ch = 4'd7; div_val = 8'd3;
      step();
      div_load = 1'b0;
      prev = clk_out[1];
      for (int k = 0; k < 30; k++) begin
         step();
         n_checks++;
         if (clk_out !== m_outv() || tick !== m_tickv()) begin
            n_fail++;
            $display("FAIL div_load k=%0d: got out=%h tick=%h expected out=%h tick=%h", k, clk_out, tick, m_outv(), m_tickv());
         end
         if (k >= 20) begin
            n_checks++;
            if (clk_out[1] === prev || tick[1] !== clk_out[1]) begin
               n_fail++;
               $display("FAIL div2_toggle k=%0d: got out1=%b tick1=%b prev=%b expected toggle", k, clk_out[1], tick[1], prev);
            end
         end
         prev = clk_out[1];
      end
   endtask

   task automatic test_enable_hold();
      rst = 1'b0; step();
      rst = 1'b1; en = 4'hF;
      for (int k = 0; k < 7; k++) step();
      en = 4'b1011;
      for (int k = 0; k < 7; k++) begin
         step();
         n_checks++;
         if (clk_out[2] !== 1'b1 || tick[2] !== 1'b0 || clk_out !== m_outv()) begin
            n_fail++;
            $display("FAIL en_hold k=%0d: got out=%h tick=%h expected out2=1 tick2=0 out=%h", k, clk_out, tick, m_outv());
         end
      end
      en = 4'hF;
      for (int k = 1; k <= 3; k++) begin
         step();
         n_checks++;
         if (clk_out[2] !== (k < 3) || clk_out !== m_outv()) begin
            n_fail++;
            $display("FAIL en_resume k=%0d: got out=%h expected out2=%b out=%h", k, clk_out, (k < 3), m_outv());
         end
      end
   endtask

   task automatic test_sync();
      for (int k = 0; k < 3; k++) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      n_checks++;
      if (clk_out !== 4'h0 || tick !== 4'h0) begin
         n_fail++; $display("FAIL sync_clear: got out=%h tick=%h expected 0/0", clk_out, tick);
      end
      for (int k = 0; k < 20; k++) begin
         step();
         n_checks++;
         if (clk_out[0] !== clk_out[3] || clk_out !== m_outv() || tick !== m_tickv()) begin
            n_fail++;
            $display("FAIL sync_align k=%0d: got out=%h tick=%h expected out=%h tick=%h", k, clk_out, tick, m_outv(), m_tickv());
         end
      end
      sync = 1'b1; div_load = 1'b1; div_ch = 4'd0; div_val = 8'd1;
      step();
      sync = 1'b0; div_load = 1'b0;
      n_checks++;
      if (clk_out !== 4'h0 || tick !== 4'h0) begin
         n_fail++; $display("FAIL sync_load_clear: got out=%h tick=%h expected 0/0", clk_out, tick);
      end
      for (int k = 1; k <= 8; k++) begin
         step();
         n_checks++;
         if (clk_out[0] !== ((k / 2) % 2 == 1) || tick[0] !== (k % 4 == 2)) begin
            n_fail++;
            $display("FAIL sync_load k=%0d: got out0=%b tick0=%b expected out0=%b tick0=%b", k, clk_out[0], tick[0], ((k / 2) % 2 == 1), (k % 4 == 2));
         end
      end
   endtask

   task automatic test_reload_phase();
      logic eo;
      rst = 1'b0; step();
      rst = 1'b1; en = 4'hF;
      for (int k = 0; k < 7; k++) step();
      div_load = 1'b1; div_ch = 4'd0; div_val = 8'd1;
      step();
      div_load = 1'b0;
      for (int j = 0; j < 10; j++) begin
         if (j > 0) step();
         eo = (j < 2) ? 1'b1 : (((j - 2) / 2) % 2 == 1);
         n_checks++;
         if (clk_out[0] !== eo || clk_out !== m_outv()) begin
            n_fail++;
            $display("FAIL reload_phase j=%0d: got out=%h expected out0=%b out=%h", j, clk_out, eo, m_outv());
         end
      end
   endtask

   task automatic test_reset_pend();
      logic [3:0] eo, et;
      rst = 1'b0; step();
      rst = 1'b1; en = 4'hF;
      for (int k = 0; k < 7; k++) step();
      div_load = 1'b1; div_ch = 4'd0; div_val = 8'd1;
      step();
      div_load = 1'b0; rst = 1'b0;
      step();
      n_checks++;
      if (clk_out !== 4'h0 || tick !== 4'h0) begin
         n_fail++; $display("FAIL reset_pend_clear: got out=%h tick=%h expected 0/0", clk_out, tick);
      end
      rst = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         eo = ((k / 5) % 2 == 1) ? 4'hF : 4'h0;
         et = (k % 10 == 5) ? 4'hF : 4'h0;
         n_checks++;
         if (clk_out !== eo || tick !== et) begin
            n_fail++;
            $display("FAIL reset_pend k=%0d: got out=%h tick=%h expected out=%h tick=%h", k, clk_out, tick, eo, et);
         end
      end
   endtask

   task automatic test_random();
      rst = 1'b0; step();
      rst = 1'b1;
      for (int k = 0; k < 300; k++) begin
         en   = 4'($urandom_range(0, 15));
         sync = ($urandom_range(0, 19) == 0);
         step();
         n_checks++;
         if (clk_out !== m_outv() || tick !== m_tickv()) begin
            n_fail++;
            $display("FAIL rand_en k=%0d: got out=%h tick=%h expected out=%h tick=%h", k, clk_out, tick, m_outv(), m_tickv());
         end
      end
      en = 4'hF;
      for (int k = 0; k < 400; k++) begin
         sync     = ($urandom_range(0, 24) == 0);
         div_load = ($urandom_range(0, 5) == 0);
         div_ch   = 4'($urandom_range(0, 7));
         div_val  = CW'($urandom_range(0, 6));
         step();
         n_checks++;
         if (clk_out !== m_outv() || tick !== m_tickv()) begin
            n_fail++;
            $display("FAIL rand_load k=%0d: got out=%h tick=%h expected out=%h tick=%h", k, clk_out, tick, m_outv(), m_tickv());
         end
      end
      sync = 1'b0; div_load = 1'b0;
   endtask

   initial begin
      for (int c = 0; c < 4; c++) begin
         m_ph[c] = 0; m_half[c] = 4; m_pend[c] = 0; m_pvld[c] = 0; m_tick[c] = 0;
      end
      #1;
      test_reset();
      test_release();
      test_div_load();
      test_enable_hold();
      test_sync();
      test_reload_phase();
      test_reset_pend();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
